// File: rtl/seg7_pkg.sv
// Shared types and constants for seven-segment display drivers.
// Segment vectors are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t       SEG_BLANK        = 7'h7F;
  localparam logic [7:0] AN_OFF           = 8'hFF;
  localparam int         PRESCALE_DEFAULT = 12500;

  localparam seg_t HEX_SEG [16] = '{
    7'b1000000, // 0
    7'b1111001, // 1
    7'b0100100, // 2
    7'b0110000, // 3
    7'b0011001, // 4
    7'b0010010, // 5
    7'b0000010, // 6
    7'b1111000, // 7
    7'b0000000, // 8
    7'b0010000, // 9
    7'b0001000, // A
    7'b0000011, // b
    7'b1000110, // C
    7'b0100001, // d
    7'b0000110, // E
    7'b0001110  // F
  };

  // Index of the most significant nonzero nibble; 0 when the word is zero.
  function automatic logic [2:0] msd_index(input logic [31:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (v[k*4 +: 4] != 4'h0) idx = 3'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle between the ALU result path and the scan driver:
// value/load/blank flow into the driver, board pins and frame pulse flow out.
interface seg7_scan_driver_if;
  import seg7_pkg::*;

  logic [31:0] value_i;
  logic        load_i;
  logic        blank_i;
  seg_t        seg_out;
  logic [7:0]  an;
  logic        frame_o;

  modport master (
    output value_i, load_i, blank_i,
    input  seg_out, an, frame_o
  );

  modport slave (
    input  value_i, load_i, blank_i,
    output seg_out, an, frame_o
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Eight-digit time-multiplexed hex display driver with frame-aligned updates.
// Optional leading-zero suppression when SEG7_LZ_BLANK_EN is defined.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT,
  parameter int NDIG     = 8
) (
  input logic               clk,
  input logic               rst_n,
  seg7_scan_driver_if.slave bus
);

  localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PCNT_MAX = PW'(PRESCALE - 1);
  localparam logic [2:0]      DIG_LAST = 3'(NDIG - 1);

  logic [PW-1:0] pcnt, pcnt_nxt;
  logic [2:0]    dig, dig_nxt;
  logic [31:0]   pending, pending_nxt;
  logic [31:0]   shown, shown_nxt;
  logic          wrap, boundary;
  logic [3:0]    nibble;
  seg_t          seg_dec;
  logic [7:0]    an_nxt;
  seg_t          seg_nxt;

  logic [7:0]    an_q;
  seg_t          seg_q;
  logic          frame_q;

  // NOTE: every signal written here gets a value before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wrap        = (pcnt == PCNT_MAX);
    pcnt_nxt    = wrap ? '0 : pcnt + 1'b1;
    dig_nxt     = wrap ? dig + 3'd1 : dig;
    boundary    = wrap && (dig == DIG_LAST);
    pending_nxt = bus.load_i ? bus.value_i : pending;
    // A load on the boundary edge reaches the new frame directly.
    shown_nxt   = boundary ? pending_nxt : shown;
    nibble      = shown_nxt[{dig_nxt, 2'b00} +: 4];
  end

  seg7_decode u_decode (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  // Pins are computed from next-state digit and value so anode and
  // segments always switch on the same edge.
  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_BLANK;
    if (!bus.blank_i) begin
      an_nxt  = ~(8'b1 << dig_nxt);
      seg_nxt = seg_dec;
`ifdef SEG7_LZ_BLANK_EN
      if (dig_nxt > msd_index(shown_nxt)) an_nxt = AN_OFF;
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt    <= '0;
      dig     <= 3'd0;
      pending <= 32'h0;
      shown   <= 32'h0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
      frame_q <= 1'b0;
    end else begin
      pcnt    <= pcnt_nxt;
      dig     <= dig_nxt;
      pending <= pending_nxt;
      shown   <= shown_nxt;
      an_q    <= an_nxt;
      seg_q   <= seg_nxt;
      frame_q <= boundary;
    end
  end

  assign bus.an      = an_q;
  assign bus.seg_out = seg_q;
  assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with PRESCALE=4 (32-cycle frame).
// Expected pin values per cycle are queued up front; a monitor pops and compares.
module tb_seg7_scan_driver;
  import seg7_pkg::*;

  typedef struct {
    int         cyc;
    logic [7:0] an;
    seg_t       seg;
    logic       seg_chk;
    logic       fr;
    string      tag;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_bad;
  exp_t exp_q[$];

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(.PRESCALE(4), .NDIG(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; cycle c shows digit (c/4)%8 of frame c/32.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Hand-computed display contents for each frame of the run.
  logic [31:0] frame_val [9] = '{32'h0, 32'h7654_3210, 32'h0000_0001,
                                 32'hDEAD_BEEF, 32'h2222_2222, 32'h2222_2222,
                                 32'h0000_00A5, 32'h0, 32'h0};
  int          top_dig   [9] = '{0, 7, 0, 7, 7, 7, 1, 0, 0};
  logic [6:0]  hex_tab  [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                 7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                                 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input exp_t e, input logic [7:0] an_a,
                       input seg_t seg_a, input logic fr_a);
    n_vec++;
    if (an_a !== e.an || fr_a !== e.fr || (e.seg_chk && seg_a !== e.seg)) begin
      n_bad++;
      $display("FAIL %s: an=%h seg=%h frame=%b, expected an=%h seg=%h frame=%b",
               e.tag, an_a, seg_a, fr_a, e.an, e.seg, e.fr);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      if (!rst_n) begin
        if (exp_q[0].cyc == 0) begin
          e = exp_q.pop_front();
          check(e, bus.an, bus.seg_out, bus.frame_o);
        end
      end else if (exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        check(e, bus.an, bus.seg_out, bus.frame_o);
      end else if (exp_q[0].cyc > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_vec++;
        n_bad++;
        $display("FAIL %s: skipped at cycle %0d", e.tag, cyc);
      end
    end
  end

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc != n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_cyc: at cycle %0d, expected %0d", cyc, n);
    end
  endtask

  // Drives a one-cycle load that is captured on edge c.
  task automatic load_at(input int c, input logic [31:0] v);
    wait_cyc(c - 1);
    bus.value_i = v;
    bus.load_i  = 1'b1;
    @(negedge clk);
    bus.load_i  = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   f, d;
    logic [3:0] nib;

    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.value_i = 32'h0;
    bus.load_i  = 1'b0;
    bus.blank_i = 1'b0;

    for (int i = 0; i < 10; i++) begin
      e = '{cyc: 0, an: 8'hFF, seg: 7'h7F, seg_chk: 1'b1, fr: 1'b0,
            tag: $sformatf("reset%0d", i)};
      exp_q.push_back(e);
    end
    for (int c = 1; c <= 256; c++) begin
      f   = c / 32;
      d   = (c / 4) % 8;
      nib = frame_val[f][d*4 +: 4];
      e.cyc     = c;
      e.an      = ~(8'b1 << d);
      e.seg     = hex_tab[nib];
      e.seg_chk = 1'b1;
      e.fr      = (c % 32 == 0);
      e.tag     = $sformatf("f%0d_cyc%0d", f, c);
`ifdef SEG7_LZ_BLANK_EN
      if (d > top_dig[f]) begin
        e.an      = 8'hFF;
        e.seg_chk = 1'b0;
      end
`endif
      if (c >= 141 && c <= 150) begin
        e.an      = 8'hFF;
        e.seg     = 7'h7F;
        e.seg_chk = 1'b1;
      end
      exp_q.push_back(e);
    end

    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    load_at(5,   32'h7654_3210);
    load_at(45,  32'h0000_0001);
    load_at(96,  32'hDEAD_BEEF);
    load_at(100, 32'h1111_1111);
    load_at(110, 32'h2222_2222);
    wait_cyc(140);
    bus.blank_i = 1'b1;
    wait_cyc(150);
    bus.blank_i = 1'b0;
    load_at(170, 32'h0000_00A5);
    load_at(200, 32'h0000_0000);
    wait_cyc(256);
    @(negedge clk);

    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
